// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and sizing helpers for the OCI trace-capture buffer.
// NIOS2_OCI_TRACE_TIMESTAMP_EN prefixes each stored entry with a free-running timestamp.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain,
    StDone
  } trace_state_e;

  localparam int unsigned OvfCntW = 16;

`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  localparam bit TimestampEn = 1'b1;
`else
  localparam bit TimestampEn = 1'b0;
`endif

  function automatic int unsigned entry_width(int unsigned dct_w, int unsigned cnt_w,
                                              int unsigned ts_w);
    return dct_w + cnt_w + (TimestampEn ? ts_w : 0);
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// Circular trace buffer with first-word fall-through read port and registered level.
// Depth must be a power of two so the pointers wrap without extra logic.
module nios2_oci_trace_fifo
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned Width = 34,
  parameter int unsigned Depth = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         wr_en_i,
  input  logic [Width-1:0]             wr_data_i,
  input  logic                         rd_ready_i,
  output logic                         rd_valid_o,
  output logic [Width-1:0]             rd_data_o,
  output logic                         full_o,
  output logic [$clog2(Depth+1)-1:0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             wr_accept, pop;

  assign full_o     = (level_q == LvlW'(Depth));
  assign rd_valid_o = (level_q != '0);
  // Full is judged on the registered level, so a same-cycle pop never frees room.
  assign wr_accept  = wr_en_i && !full_o;
  assign pop        = rd_valid_o && rd_ready_i;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o    = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// OCI trace capture: capture/drain FSM, saturating overflow count and circular buffer.
// Define NIOS2_OCI_TRACE_TIMESTAMP_EN to store {timestamp, dct_count, dct_buffer} entries.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DctW  = 30,
  parameter int unsigned CntW  = 4,
  parameter int unsigned Depth = 16,
  parameter int unsigned TsW   = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      cap_en_i,
  input  logic                                      dct_valid_i,
  input  logic [DctW-1:0]                           dct_buffer_i,
  input  logic [CntW-1:0]                           dct_count_i,
  input  logic                                      test_ending_i,
  output logic                                      rd_valid_o,
  input  logic                                      rd_ready_i,
  output logic [entry_width(DctW, CntW, TsW)-1:0]   rd_data_o,
  output logic [$clog2(Depth+1)-1:0]                level_o,
  output logic [OvfCntW-1:0]                        overflow_cnt_o,
  output logic                                      test_has_ended_o
);

  localparam int unsigned EntryW = entry_width(DctW, CntW, TsW);
  localparam int unsigned LvlW   = $clog2(Depth + 1);

  trace_state_e        state_q, state_d;
  logic [OvfCntW-1:0]  ovf_q, ovf_d;
  logic [EntryW-1:0]   wr_entry;
  logic [LvlW-1:0]     level_after;
  logic                wr_en, full, pop;

  assign wr_en       = (state_q == StCapture) && dct_valid_i;
  assign pop         = rd_valid_o && rd_ready_i;
  assign level_after = level_o - LvlW'(pop);

`ifdef NIOS2_OCI_TRACE_TIMESTAMP_EN
  logic [TsW-1:0] ts_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) ts_q <= '0;
    else         ts_q <= ts_q + 1'b1;
  end

  assign wr_entry = {ts_q, dct_count_i, dct_buffer_i};
`else
  assign wr_entry = {dct_count_i, dct_buffer_i};
`endif

  nios2_oci_trace_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_entry),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .full_o     (full),
    .level_o    (level_o)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (test_ending_i) state_d = StDrain;
        else if (cap_en_i) state_d = StCapture;
      end
      StCapture: begin
        if (test_ending_i)  state_d = StDrain;
        else if (!cap_en_i) state_d = StIdle;
      end
      // Done is decided on the level left after this cycle's pop.
      StDrain: begin
        if (level_after == '0) state_d = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_cnt_o   = ovf_q;
  assign test_has_ended_o = (state_q == StDone);

endmodule

// File: doc/nios2_oci_trace_capture.md
# nios2_oci_trace_capture

Parametrised trace-capture buffer for the Nios II OCI debug path. It succeeds the fixed 30-bit/4-bit capture test bench. It accepts debug-capture-trace (DCT) frames of configurable width, stores them in a circular buffer of configurable depth, and streams them out over a valid/ready port. It also implements the end-of-test handshake: stop capture, drain, then report ended. It sits between the OCI trace source and the debug/JTAG readout logic.

## Interface
- DCT_W, 30: width of dct_buffer
- CNT_W, 4: width of dct_count tag
- DEPTH, 16: buffer entries; power of two, ≥2
- TS_W, 16: timestamp width; used only with the timestamp macro
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- cap_en  in  1  capture enable; level-sensitive
- dct_valid  in  1  frame present this cycle
- dct_buffer  in  DCT_W  frame payload
- dct_count  in  CNT_W  frame tag/count, stored verbatim
- test_ending  in  1  request to end the test; a single-cycle pulse is sufficient
- rd_valid  out  1  rd_data holds an entry
- rd_ready  in  1  consumer accepts; pop on rd_valid&&rd_ready
- rd_data  out  ENTRY_W  oldest entry
- level  out  $clog2(DEPTH+1)  entries stored
- overflow_cnt  out  16  dropped frames, saturating
- test_has_ended  out  1  drain complete; sticky until reset

## Operation
- ENTRY_W = CNT_W+DCT_W, with entry = {dct_count, dct_buffer}. With the timestamp macro, ENTRY_W = TS_W+CNT_W+DCT_W and entry = {timestamp, dct_count, dct_buffer}.
- States are IDLE, CAPTURE, DRAIN and DONE. IDLE is the reset state.
- IDLE→CAPTURE when cap_en=1. CAPTURE→IDLE when cap_en=0 (pause); the buffer contents are kept.
- IDLE or CAPTURE→DRAIN on test_ending=1. test_ending takes priority over cap_en in the same cycle.
- DRAIN→DONE when level==0. The check uses the level after any pop in the current cycle.
- DONE is left only by reset. test_ending in DRAIN or DONE is ignored.
- Write: in CAPTURE with dct_valid=1 and level<DEPTH, the frame is written. If level==DEPTH, the frame is dropped and overflow_cnt increments, saturating at 0xFFFF.
- A frame arriving while full is dropped even if a pop occurs in the same cycle. Full is judged on the registered level.
- dct_valid in IDLE, DRAIN or DONE is ignored and is not counted as overflow.
- The read side is active in every state. A pop when empty is impossible because rd_valid=0.
- On a simultaneous write and pop, level is unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-operation clears all state on the next edge: contents are discarded and pointers, level, overflow_cnt, timestamp and state return to their reset values.

## Timing
- Reset values: rd_valid=0, rd_data=0, level=0, overflow_cnt=0, test_has_ended=0, state=IDLE.
- Write-to-read latency is 1 cycle: a frame written at edge N gives rd_valid=1 after edge N with that data (first-word fall-through).
- A pop at edge N presents the next entry immediately after edge N, or drops rd_valid if the buffer is now empty.
- level and overflow_cnt are registered and update on the edge of the event.
- test_has_ended rises on the edge that enters DONE. Minimum: 1 cycle after test_ending when the buffer is empty (IDLE→DRAIN, then DRAIN→DONE).
- The timestamp is a free-running TS_W counter from reset. It wraps modulo 2^TS_W and is sampled at the write edge.

## Configuration
- NIOS2_OCI_TRACE_TIMESTAMP_EN defined: the timestamp counter exists and each entry is prefixed with TS_W timestamp bits.
- NIOS2_OCI_TRACE_TIMESTAMP_EN undefined: no counter, ENTRY_W = CNT_W+DCT_W, and TS_W is ignored.

## Structure
- Package nios2_oci_trace_pkg holds:
  - the state enum (IDLE, CAPTURE, DRAIN, DONE)
  - the overflow counter width constant (16)
  - a function computing ENTRY_W from the parameters
- Sub-module nios2_oci_trace_fifo holds the storage array, the read/write pointers and the level counter, with FWFT output.
- The top level holds the FSM, the overflow counter and the optional timestamp.

## Test plan
- Reset, cap_en=1, 3 frames {count 1..3, data 0x1..0x3}, rd_ready=1 → rd_data emerges in order, one cycle after each write; level ends at 0.
- rd_ready=0, 20 frames with DEPTH=16 → level=16, overflow_cnt=4, and the first 16 frames read back intact.
- Hold overflow_cnt=0xFFFF by forcing continuous drops → the count holds at 0xFFFF.
- 5 entries stored, test_ending pulse, rd_ready=1 → further dct_valid is ignored, 5 entries drain, and test_has_ended rises on the edge after the last pop and stays high.
- Full buffer with simultaneous dct_valid and pop → frame dropped, overflow_cnt+1, level=15.
- Reset asserted mid-drain with 7 entries → next cycle level=0, rd_valid=0, test_has_ended=0, state IDLE. With NIOS2_OCI_TRACE_TIMESTAMP_EN, the timestamp restarts at 0 and the stored timestamps increase by write-cycle spacing.
